// File: rtl/acc_demo_flag_rx_drv_pkg.sv
// Shared definitions for the acc-demo/scan sync-word serial link.
// The transmitter imports the same sync word constants.
package acc_demo_flag_rx_drv_pkg;

    localparam logic [15:0] SYNC_ACC_FLAG_HIGH   = 16'hACC1;
    localparam logic [15:0] SYNC_ACC_FLAG_LOW    = 16'hACC0;
    localparam logic [15:0] SYNC_WORD_SCAN_BEGIN = 16'h5A51;
    localparam logic [15:0] SYNC_WORD_SCAN_TEST  = 16'h5A53;
    localparam logic [15:0] SYNC_WORD_SCAN_END   = 16'h5A50;

    typedef enum logic [1:0] {
        RX_HUNT,
        RX_IDLE,
        RX_SHIFT
    } rx_state_e;

endpackage

// File: rtl/acc_demo_flag_rx_drv_serial_rx.sv
// Oversampling serial receiver: synchronizers, SCLK rising-edge detect,
// HUNT/IDLE/SHIFT framing FSM and the MSB-group-first deserializer.
module acc_demo_flag_rx_drv_serial_rx #(
    parameter int DATA_WIDTH   = 16,
    parameter int SERIAL_MODE  = 1,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   sclk_i,
    input  logic [SERIAL_MODE-1:0] sdata_i,
    output logic [DATA_WIDTH-1:0]  word_o,
    output logic                   word_valid_o,
    output logic                   frame_err_o
);
    import acc_demo_flag_rx_drv_pkg::*;

    localparam int GROUPS = DATA_WIDTH / SERIAL_MODE;
    localparam int CNT_W  = $clog2(GROUPS + 1);
    localparam int TO_W   = $clog2(IDLE_TIMEOUT + 1);

    logic [2:0]             sclk_sync_q, sclk_sync_d;
    logic [SERIAL_MODE-1:0] sdata_s1_q, sdata_s1_d;
    logic [SERIAL_MODE-1:0] sdata_s2_q, sdata_s2_d;
    rx_state_e              state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
    logic [TO_W-1:0]        idle_cnt_q, idle_cnt_d;
    logic [DATA_WIDTH-1:0]  word_q, word_d;
    logic                   word_valid_q, word_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic                   rise;
    logic                   timeout;
    logic [DATA_WIDTH-1:0]  shift_next;

    assign rise       = sclk_sync_q[1] & ~sclk_sync_q[2];
    // An edge arriving on the last count wins over the timeout.
    assign timeout    = (idle_cnt_q == TO_W'(IDLE_TIMEOUT - 1)) && !rise;
    assign shift_next = {shift_q[DATA_WIDTH-SERIAL_MODE-1:0], sdata_s2_q};

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[1:0], sclk_i};
        sdata_s1_d   = sdata_i;
        sdata_s2_d   = sdata_s1_q;
        state_d      = state_q;
        shift_d      = shift_q;
        edge_cnt_d   = edge_cnt_q;
        idle_cnt_d   = rise ? '0 : idle_cnt_q + TO_W'(1);
        word_d       = word_q;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            RX_HUNT: begin
                if (timeout) begin
                    state_d    = RX_IDLE;
                    idle_cnt_d = '0;
                end
            end
            RX_IDLE: begin
                idle_cnt_d = '0;
                if (rise) begin
                    shift_d    = shift_next;
                    edge_cnt_d = CNT_W'(1);
                    state_d    = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (rise) begin
                    shift_d = shift_next;
                    if (edge_cnt_q == CNT_W'(GROUPS - 1)) begin
                        word_d       = shift_next;
                        word_valid_d = 1'b1;
                        edge_cnt_d   = '0;
                        state_d      = RX_IDLE;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                end else if (timeout) begin
                    frame_err_d = 1'b1;
                    shift_d     = '0;
                    edge_cnt_d  = '0;
                    idle_cnt_d  = '0;
                    state_d     = RX_IDLE;
                end
            end
            default: state_d = RX_HUNT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q  <= '0;
            sdata_s1_q   <= '0;
            sdata_s2_q   <= '0;
            state_q      <= RX_HUNT;
            shift_q      <= '0;
            edge_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            sdata_s1_q   <= sdata_s1_d;
            sdata_s2_q   <= sdata_s2_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            edge_cnt_q   <= edge_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/acc_demo_flag_rx_drv.sv
// Sync-word receiver top: decodes acc-demo flag and PMT scan levels.
// Define ACC_DEMO_RX_ERR_CNT_EN to add the saturating err_cnt_o counter.
module acc_demo_flag_rx_drv #(
    parameter int DATA_WIDTH   = 16,
    parameter int SERIAL_MODE  = 1,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   SPI_MCLK,
    input  logic [SERIAL_MODE-1:0] SPI_MOSI,
    output logic                   rx_valid_o,
    output logic [DATA_WIDTH-1:0]  rx_data_o,
    output logic                   acc_demo_flag_o,
    output logic                   pmt_start_en_o,
    output logic                   pmt_start_test_en_o,
    output logic                   unknown_word_o,
    output logic                   frame_err_o
`ifdef ACC_DEMO_RX_ERR_CNT_EN
    ,
    output logic [15:0]            err_cnt_o
`endif
);
    import acc_demo_flag_rx_drv_pkg::*;

    logic [DATA_WIDTH-1:0] word;
    logic                  word_valid;
    logic                  word_frame_err;

    acc_demo_flag_rx_drv_serial_rx #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SERIAL_MODE (SERIAL_MODE),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) u_serial_rx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sclk_i      (SPI_MCLK),
        .sdata_i     (SPI_MOSI),
        .word_o      (word),
        .word_valid_o(word_valid),
        .frame_err_o (word_frame_err)
    );

    logic                  rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  acc_q, acc_d;
    logic                  en_q, en_d;
    logic                  tst_q, tst_d;
    logic                  unknown_q, unknown_d;
    logic                  frame_err_q, frame_err_d;

    // Each word only touches its own field group; everything else holds.
    always_comb begin
        rx_valid_d  = word_valid;
        rx_data_d   = rx_data_q;
        acc_d       = acc_q;
        en_d        = en_q;
        tst_d       = tst_q;
        unknown_d   = 1'b0;
        frame_err_d = word_frame_err;
        if (word_valid) begin
            rx_data_d = word;
            case (word)
                DATA_WIDTH'(SYNC_ACC_FLAG_HIGH):   acc_d = 1'b1;
                DATA_WIDTH'(SYNC_ACC_FLAG_LOW):    acc_d = 1'b0;
                DATA_WIDTH'(SYNC_WORD_SCAN_BEGIN): begin en_d = 1'b1; tst_d = 1'b0; end
                DATA_WIDTH'(SYNC_WORD_SCAN_TEST):  begin en_d = 1'b1; tst_d = 1'b1; end
                DATA_WIDTH'(SYNC_WORD_SCAN_END):   begin en_d = 1'b0; tst_d = 1'b0; end
                default:                           unknown_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            acc_q       <= 1'b0;
            en_q        <= 1'b0;
            tst_q       <= 1'b0;
            unknown_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            acc_q       <= acc_d;
            en_q        <= en_d;
            tst_q       <= tst_d;
            unknown_q   <= unknown_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_valid_o          = rx_valid_q;
    assign rx_data_o           = rx_data_q;
    assign acc_demo_flag_o     = acc_q;
    assign pmt_start_en_o      = en_q;
    assign pmt_start_test_en_o = tst_q;
    assign unknown_word_o      = unknown_q;
    assign frame_err_o         = frame_err_q;

`ifdef ACC_DEMO_RX_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // unknown and frame errors are mutually exclusive, so +1 is enough.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((unknown_d || frame_err_d) && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_acc_demo_flag_rx_drv.sv
// Scoreboard bench for acc_demo_flag_rx_drv: one SERIAL_MODE=1 and one SERIAL_MODE=4 instance.
module tb_acc_demo_flag_rx_drv;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        mclk1 = 1'b0;
    logic [0:0]  mosi1 = '0;
    logic        rxv1, acc1, en1, tst1, unk1, ferr1;
    logic [15:0] rxd1;
    logic        mclk4 = 1'b0;
    logic [3:0]  mosi4 = '0;
    logic        rxv4, acc4, en4, tst4, unk4, ferr4;
    logic [15:0] rxd4;
`ifdef ACC_DEMO_RX_ERR_CNT_EN
    logic [15:0] err1, err4;
`endif

    acc_demo_flag_rx_drv #(.DATA_WIDTH(16), .SERIAL_MODE(1), .IDLE_TIMEOUT(64)) dut1 (
        .clk_i(clk), .rst_i(rst), .SPI_MCLK(mclk1), .SPI_MOSI(mosi1),
        .rx_valid_o(rxv1), .rx_data_o(rxd1), .acc_demo_flag_o(acc1),
        .pmt_start_en_o(en1), .pmt_start_test_en_o(tst1),
        .unknown_word_o(unk1), .frame_err_o(ferr1)
`ifdef ACC_DEMO_RX_ERR_CNT_EN
        , .err_cnt_o(err1)
`endif
    );

    acc_demo_flag_rx_drv #(.DATA_WIDTH(16), .SERIAL_MODE(4), .IDLE_TIMEOUT(64)) dut4 (
        .clk_i(clk), .rst_i(rst), .SPI_MCLK(mclk4), .SPI_MOSI(mosi4),
        .rx_valid_o(rxv4), .rx_data_o(rxd4), .acc_demo_flag_o(acc4),
        .pmt_start_en_o(en4), .pmt_start_test_en_o(tst4),
        .unknown_word_o(unk4), .frame_err_o(ferr4)
`ifdef ACC_DEMO_RX_ERR_CNT_EN
        , .err_cnt_o(err4)
`endif
    );

    typedef struct {
        logic [15:0] data;
        logic        acc, en, tst, unk;
    } exp_t;

    exp_t q1[$], q4[$];
    exp_t m1, m4, e1, e4;
    int   checks = 0, errors = 0;
    int   fin1 = 0, fin4 = 0, ferr_cnt = 0, m_err = 0;

    function automatic exp_t predict(input logic [15:0] w, input exp_t prev);
        exp_t e;
        e = prev;
        e.data = w;
        e.unk  = 1'b0;
        case (w)
            16'hACC1: e.acc = 1'b1;
            16'hACC0: e.acc = 1'b0;
            16'h5A51: begin e.en = 1'b1; e.tst = 1'b0; end
            16'h5A53: begin e.en = 1'b1; e.tst = 1'b1; end
            16'h5A50: begin e.en = 1'b0; e.tst = 1'b0; end
            default:  e.unk = 1'b1;
        endcase
        return e;
    endfunction

    // Scoreboard monitors: compare on every rx_valid pulse
    always @(negedge clk) begin
        if (rxv1) begin
            if (q1.size() == 0) begin
                errors++; checks++;
                $display("FAIL unexpected_word1 got %h wanted no word", rxd1);
            end else begin
                e1 = q1.pop_front();
                checks += 5;
                if (rxd1 !== e1.data) begin errors++; $display("FAIL data1 got %h want %h", rxd1, e1.data); end
                if ({acc1, en1, tst1} !== {e1.acc, e1.en, e1.tst}) begin
                    errors++; $display("FAIL levels1 got %b want %b", {acc1, en1, tst1}, {e1.acc, e1.en, e1.tst});
                end
                if (unk1 !== e1.unk) begin errors++; $display("FAIL unknown1 got %b want %b", unk1, e1.unk); end
                if (cyc - fin1 != 4) begin errors++; $display("FAIL latency1 got %0d want 4", cyc - fin1); end
                if (ferr1 !== 1'b0) begin errors++; $display("FAIL ferr_with_valid1 got %b want 0", ferr1); end
            end
        end else if (unk1) begin
            errors++; $display("FAIL unknown_without_valid1 got 1 want 0");
        end
        if (ferr1) ferr_cnt++;
    end

    always @(negedge clk) begin
        if (rxv4) begin
            if (q4.size() == 0) begin
                errors++; checks++;
                $display("FAIL unexpected_word4 got %h wanted no word", rxd4);
            end else begin
                e4 = q4.pop_front();
                checks += 4;
                if (rxd4 !== e4.data) begin errors++; $display("FAIL data4 got %h want %h", rxd4, e4.data); end
                if ({acc4, en4, tst4} !== {e4.acc, e4.en, e4.tst}) begin
                    errors++; $display("FAIL levels4 got %b want %b", {acc4, en4, tst4}, {e4.acc, e4.en, e4.tst});
                end
                if (unk4 !== e4.unk) begin errors++; $display("FAIL unknown4 got %b want %b", unk4, e4.unk); end
                if (cyc - fin4 != 4) begin errors++; $display("FAIL latency4 got %0d want 4", cyc - fin4); end
            end
        end
    end

    // One SCLK rising edge; rise-to-rise spacing is 'period' clk cycles (>= 4)
    task automatic rise1(input logic b, input int period, input logic last);
        @(negedge clk);
        mosi1 = b;
        mclk1 = 1'b1;
        if (last) fin1 = cyc;
        repeat (2) @(negedge clk);
        mclk1 = 1'b0;
        repeat (period - 3) @(negedge clk);
    endtask

    task automatic rise4(input logic [3:0] g, input int period, input logic last);
        @(negedge clk);
        mosi4 = g;
        mclk4 = 1'b1;
        if (last) fin4 = cyc;
        repeat (2) @(negedge clk);
        mclk4 = 1'b0;
        repeat (period - 3) @(negedge clk);
    endtask

    task automatic send1(input logic [15:0] w, input int from, input int to);
        for (int i = from; i < to; i++) rise1(w[15-i], 4, i == 15);
    endtask

    task automatic word1(input logic [15:0] w);
        m1 = predict(w, m1);
        q1.push_back(m1);
        if (m1.unk) m_err++;
        send1(w, 0, 16);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q1.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d pending want 0", name, q1.size() + q4.size());
            q1.delete();
            q4.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_err_cnt(input string name);
`ifdef ACC_DEMO_RX_ERR_CNT_EN
        checks++;
        if (err1 !== 16'(m_err)) begin
            errors++; $display("FAIL %s_err_cnt got %0d want %0d", name, err1, m_err);
        end
`else
        if (name.len() == 0) $display("empty check name");
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1;
        m1 = '{data: 16'h0, acc: 1'b0, en: 1'b0, tst: 1'b0, unk: 1'b0};
        m4 = m1;
        repeat (3) @(negedge clk);
        checks += 3;
        if ({rxv1, acc1, en1, tst1, unk1, ferr1} !== 6'b0) begin
            errors++; $display("FAIL reset_flags1 got %b want 000000", {rxv1, acc1, en1, tst1, unk1, ferr1});
        end
        if (rxd1 !== 16'h0) begin errors++; $display("FAIL reset_data1 got %h want 0000", rxd1); end
        if ({rxv4, rxd4, acc4, en4, tst4, unk4, ferr4} !== 22'b0) begin
            errors++; $display("FAIL reset_dut4 got %h want 0", {rxv4, rxd4, acc4, en4, tst4, unk4, ferr4});
        end
        rst = 1'b0;
        repeat (70) @(negedge clk);
    endtask

    task automatic test_acc_flag;
        word1(16'hACC1);
        drain("acc_flag");
    endtask

    task automatic test_back_to_back;
        word1(16'h5A53);
        word1(16'h5A50);
        drain("back_to_back");
    endtask

    task automatic test_unknown;
        word1(16'h1234);
        drain("unknown");
        check_err_cnt("unknown");
    endtask

    task automatic test_frame_err;
        ferr_cnt = 0;
        send1(16'h5A51, 0, 9);
        repeat (80) @(negedge clk);
        checks++;
        if (ferr_cnt != 1) begin errors++; $display("FAIL frame_err_count got %0d want 1", ferr_cnt); end
        m_err++;
        check_err_cnt("frame_err");
        word1(16'h5A51);
        drain("after_frame_err");
    endtask

    task automatic test_timeout_boundary;
        logic [15:0] w;
        w = 16'hACC0;
        // Gap of IDLE_TIMEOUT cycles between rises: the edge must win
        m1 = predict(w, m1);
        q1.push_back(m1);
        for (int i = 0; i < 16; i++) rise1(w[15-i], (i == 6) ? 64 : 4, i == 15);
        drain("boundary_edge_wins");
        // One cycle longer: timeout fires, the late edge opens a new frame that also times out
        ferr_cnt = 0;
        rise1(1'b1, 4, 1'b0);
        rise1(1'b0, 4, 1'b0);
        rise1(1'b1, 65, 1'b0);
        rise1(1'b1, 4, 1'b0);
        repeat (80) @(negedge clk);
        checks++;
        if (ferr_cnt != 2) begin errors++; $display("FAIL boundary_timeout got %0d want 2", ferr_cnt); end
        m_err += 2;
        check_err_cnt("boundary");
    endtask

    task automatic test_reset_midframe;
        ferr_cnt = 0;
        send1(16'hACC1, 0, 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m1 = '{data: 16'h0, acc: 1'b0, en: 1'b0, tst: 1'b0, unk: 1'b0};
        m4 = m1;
        m_err = 0;
        checks++;
        if ({rxd1, acc1, en1, tst1} !== 19'b0) begin
            errors++; $display("FAIL midframe_reset_state got %h want 0", {rxd1, acc1, en1, tst1});
        end
        send1(16'hACC1, 5, 16);
        repeat (80) @(negedge clk);
        checks++;
        if (ferr_cnt != 0) begin errors++; $display("FAIL midframe_no_ferr got %0d want 0", ferr_cnt); end
        check_err_cnt("midframe");
        word1(16'hACC0);
        drain("after_midframe");
    endtask

    task automatic test_mode4;
        logic [15:0] w;
        w = 16'h5A51;
        m4 = predict(w, m4);
        q4.push_back(m4);
        for (int i = 0; i < 4; i++) rise4(w[15-4*i -: 4], 4, i == 3);
        drain("mode4");
    endtask

    initial begin
        test_reset;
        test_acc_flag;
        test_back_to_back;
        test_unknown;
        test_frame_err;
        test_timeout_boundary;
        test_reset_midframe;
        test_mode4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_demo_flag_rx_drv.md
# acc_demo_flag_rx_drv

Receive-side counterpart of the acc-demo/scan sync-word serial link. The block oversamples the incoming serial clock and data lanes in the local `clk_i` domain and deserializes DATA_WIDTH-bit sync words. It decodes the accelerometer-demo flag, the PMT scan-enable and the scan-test-enable state from those words. It sits on the downstream board, where it feeds the PMT acquisition start logic and the acc-demo gating logic.

## Interface
- DATA_WIDTH, 16, sync word width in bits.
- SERIAL_MODE, 1, number of data lanes; legal values are 1, 2, 4, 8.
- IDLE_TIMEOUT, 64, number of `clk_i` cycles without a serial clock rising edge that ends a frame or completes a hunt.
- `clk_i` in 1: system clock. Must be at least 4× the serial clock frequency.
- `rst_i` in 1: reset, synchronous, active-high.
- `SPI_MCLK` in 1: serial clock from the transmitter. Asynchronous to `clk_i`.
- `SPI_MOSI` in SERIAL_MODE: serial data lanes. Asynchronous to `clk_i`.
- `rx_valid_o` out 1: one-cycle pulse when a complete word has been received.
- `rx_data_o` out DATA_WIDTH: last received word. Held between pulses.
- `acc_demo_flag_o` out 1: decoded acc-demo flag level.
- `pmt_start_en_o` out 1: decoded scan-active level.
- `pmt_start_test_en_o` out 1: decoded scan-test level.
- `unknown_word_o` out 1: one-cycle pulse when a received word is not in the sync set.
- `frame_err_o` out 1: one-cycle pulse when a partial word is discarded on timeout.

## Operation
- Input conditioning:
  - `SPI_MCLK` and `SPI_MOSI` each pass through 2-FF synchronizers, then one extra stage on the clock.
  - A rising edge is detected when stage2 is 1 and stage3 is 0.
  - Data is taken from stage2 in the cycle the edge is detected.
- Lane mapping:
  - Each edge carries SERIAL_MODE bits, and the most significant group is sent first.
  - Lane SERIAL_MODE-1 carries the most significant bit of its group.
  - A word is complete after DATA_WIDTH/SERIAL_MODE edges.
- State machine `HUNT` → `IDLE` ↔ `SHIFT`:
  - `HUNT` (reset state): edges are ignored. An idle counter counts up while there is no edge and clears on every edge. When it reaches IDLE_TIMEOUT, go to `IDLE`.
  - `IDLE`: the first edge loads the first bit group, sets the edge count to 1 and goes to `SHIFT`.
  - `SHIFT`: each edge shifts in a group.
    - On the final group, load `rx_data_o`, pulse `rx_valid_o`, decode, and return to `IDLE`.
    - If IDLE_TIMEOUT cycles pass with no edge, pulse `frame_err_o`, discard the partial word and go to `IDLE`.
- Decode, registered in the same cycle as `rx_valid_o`:
  - 0xACC1: `acc_demo_flag_o` = 1.
  - 0xACC0: `acc_demo_flag_o` = 0.
  - 0x5A51: `pmt_start_en_o` = 1, `pmt_start_test_en_o` = 0.
  - 0x5A53: `pmt_start_en_o` = 1, `pmt_start_test_en_o` = 1.
  - 0x5A50: `pmt_start_en_o` = 0, `pmt_start_test_en_o` = 0.
  - Any other word: pulse `unknown_word_o`. All decoded levels keep their previous value.
- Each word affects only its own field group; the other outputs hold.
- Back-to-back words need no gap. The edge after a completed word starts the next word.

## Timing
- Reset values: all outputs are 0, `rx_data_o` = 0, state = `HUNT`, counters = 0.
- Reset mid-frame: the partial word is dropped without a `frame_err_o` pulse. The block re-hunts, so words are not accepted until IDLE_TIMEOUT idle cycles have been seen.
- Latency: `rx_valid_o` and the decoded outputs change 4 `clk_i` cycles after the final rising edge of `SPI_MCLK` at the pin: 2 synchronizer cycles, 1 edge-detect cycle, 1 register cycle.
- Timeout boundary:
  - No edge for exactly IDLE_TIMEOUT cycles: the timeout fires.
  - An edge in the cycle the counter reaches IDLE_TIMEOUT-1: the edge wins and the counter clears.
- `rx_valid_o` and `frame_err_o` are never asserted in the same cycle.
- `unknown_word_o` is asserted only together with `rx_valid_o`.

## Configuration
- `ACC_DEMO_RX_ERR_CNT_EN` defined:
  - Adds output `err_cnt_o` (16 bits), which counts `unknown_word_o` plus `frame_err_o` pulses.
  - The counter saturates at 0xFFFF.
  - It clears on `rst_i`.
- `ACC_DEMO_RX_ERR_CNT_EN` undefined: the port and the counter are absent, and all other behaviour is identical.

## Structure
- Shared package holds:
  - Sync word constants SYNC_ACC_FLAG_HIGH/LOW, SYNC_WORD_SCAN_BEGIN/TEST/END. The transmitter must use the same package.
  - The receive FSM state enum.
- One sub-module `serial_rx`: synchronizers, edge detect, HUNT/IDLE/SHIFT FSM and shifter. Outputs are word plus valid plus frame_err.
- The top level holds only the decode registers and the optional counter.

## Test plan
- After reset: drive 64 idle cycles, then word 0xACC1 with SERIAL_MODE=1 → `rx_valid_o` pulse, `rx_data_o`=0xACC1, `acc_demo_flag_o`=1, 4 cycles after the last edge.
- Send 0x5A53, then 0x5A50 back-to-back → `pmt_start_en_o` and `pmt_start_test_en_o` go to 1/1, then 0/0; `acc_demo_flag_o` is unchanged.
- Send 0x1234 → `unknown_word_o` pulse; all levels hold. With `ACC_DEMO_RX_ERR_CNT_EN` defined, `err_cnt_o`=1.
- Send 9 edges, then stay idle for 64 cycles → exactly one `frame_err_o` pulse and no `rx_valid_o`. A following 0x5A51 decodes correctly.
- Assert `rst_i` after edge 5 of a word, then send the remaining edges without a gap → no output. After 64 idle cycles, 0xACC0 decodes.
- SERIAL_MODE=4: 0x5A51 sent in 4 edges → `pmt_start_en_o`=1, `pmt_start_test_en_o`=0.
